// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: next-PC op codes, FSM encodings and PC range defaults shared by pc_ctrl, NPC and decoder
package pc_ctrl_pkg;
  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam logic [31:0] PC_MAX_DEF   = 32'h0000_6FFC;
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_UPDATE, S_HALT} state_t;
  function automatic logic pc_legal(input logic [31:0] t, input logic [31:0] lo, input logic [31:0] hi);
    return (t[1:0] == 2'b00) && (t >= lo) && (t <= hi);
  endfunction
endpackage

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch/execute/update sequencer owning the PC, instruction latch and retire counter
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter logic [31:0] PC_MAX   = PC_MAX_DEF,
  parameter int          FETCH_TO = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  npc_op_in,
  input  logic        br_taken,
  input  logic [31:0] npc_in,
  input  logic [31:0] pc4_in,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] instr_in,
  input  logic        ex_done,
  output logic [31:0] pc,
  output logic [1:0]  npc_op,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] retired,
  output logic        halt
);
  localparam logic [4:0] TO_LAST = 5'(FETCH_TO - 1);
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, ret_q, ret_d;
  logic [4:0]  wait_q, wait_d;
  logic        op_active;
  logic [31:0] target;
  assign op_active   = (state_q == S_EXEC) || (state_q == S_UPDATE);
  assign npc_op      = !op_active ? NPC_PC4 : (npc_op_in == NPC_BR && !br_taken) ? NPC_PC4 : npc_op_in;
  assign target      = (npc_op != NPC_PC4) ? npc_in : pc4_in;
  assign imem_req    = state_q == S_FETCH;
  assign instr_valid = state_q == S_EXEC;
  assign halt        = state_q == S_HALT;
  assign pc          = pc_q;
  assign instr_out   = instr_q;
  assign retired     = ret_q;
  // next state: an ack wins over a same-cycle timeout; an illegal target freezes pc and halts
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ret_d   = ret_q;
    wait_d  = '0;
    case (state_q)
      S_FETCH:
        if (imem_ack) begin
          instr_d = instr_in;
          state_d = S_EXEC;
        end else if (wait_q == TO_LAST) state_d = S_HALT;
        else wait_d = wait_q + 5'd1;
      S_EXEC: state_d = ex_done ? S_UPDATE : S_EXEC;
      S_UPDATE: begin
        ret_d   = ret_q + 32'd1;
        pc_d    = pc_legal(target, PC_RESET, PC_MAX) ? target : pc_q;
        state_d = pc_legal(target, PC_RESET, PC_MAX) ? S_FETCH : S_HALT;
      end
      default: ;
    endcase
  end
  // state registers with synchronous reset back to a fresh fetch at PC_RESET
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= PC_RESET;
      instr_q <= '0;
      ret_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ret_q   <= ret_d;
      wait_q  <= wait_d;
    end
  end
endmodule
